// File: rtl/lsu_pkg.sv
// Shared LSU definitions: funct3 width codes, FSM states and request legality.
package lsu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned F3_WIDTH = 3;

  localparam logic [F3_WIDTH-1:0] F3_B  = 3'b000;
  localparam logic [F3_WIDTH-1:0] F3_H  = 3'b001;
  localparam logic [F3_WIDTH-1:0] F3_W  = 3'b010;
  localparam logic [F3_WIDTH-1:0] F3_BU = 3'b100;
  localparam logic [F3_WIDTH-1:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RMW_RD = 2'd2,
    ST_WRITE  = 2'd3
  } lsu_state_e;

  // High when a request must be rejected (misaligned or unsupported width code).
  function automatic logic req_illegal(input logic we, input logic [F3_WIDTH-1:0] f3,
                                       input logic [1:0] a_lo);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = a_lo[0];
      F3_W:    bad = |a_lo;
      F3_BU:   bad = we;
      F3_HU:   bad = we | a_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte/halfword lane extraction for loads and lane merge for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [F3_WIDTH-1:0] i_funct3,
  input  logic [1:0]          i_addr_lo,
  input  logic [XLEN-1:0]     i_rdata,
  input  logic [15:0]         i_wdata,
  output logic [XLEN-1:0]     o_ld_data_c,
  output logic [XLEN-1:0]     o_st_word_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [4:0]  w_bit_ofs;

  always_comb begin
    w_bit_ofs = {i_addr_lo, 3'b000};
    w_byte    = i_rdata[w_bit_ofs +: 8];
    w_half    = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    case (i_funct3)
      F3_B:    o_ld_data_c = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_ld_data_c = {{16{w_half[15]}}, w_half};
      F3_BU:   o_ld_data_c = {24'd0, w_byte};
      F3_HU:   o_ld_data_c = {16'd0, w_half};
      default: o_ld_data_c = i_rdata;
    endcase

    // Store merge: only the addressed lane is replaced, the rest keeps memory contents.
    o_st_word_c = i_rdata;
    if (i_funct3 == F3_B) begin
      o_st_word_c[w_bit_ofs +: 8] = i_wdata[7:0];
    end else if (i_funct3 == F3_H) begin
      if (i_addr_lo[1]) o_st_word_c[31:16] = i_wdata;
      else              o_st_word_c[15:0]  = i_wdata;
    end
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single-outstanding request FSM over a word-wide data memory,
// with read-modify-write for byte/halfword stores.
module lsu
  import lsu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [F3_WIDTH-1:0] req_funct3,
  input  logic [XLEN-1:0]     req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_rdata,
  output logic                resp_err,
  output logic [XLEN-1:0]     mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic                mem_w_en,
  output logic                mem_read_en,
  input  logic [XLEN-1:0]     mem_rdata
);

  lsu_state_e          r_state, w_state_nxt;
  logic [XLEN-1:0]     r_addr, w_addr_nxt;
  logic [F3_WIDTH-1:0] r_funct3, w_funct3_nxt;
  logic [15:0]         r_wdata, w_wdata_nxt;
  logic                r_resp_valid, w_resp_valid_nxt;
  logic                r_resp_err, w_resp_err_nxt;
  logic [XLEN-1:0]     r_resp_rdata, w_resp_rdata_nxt;
  logic [XLEN-1:0]     r_mem_addr, w_mem_addr_nxt;
  logic [XLEN-1:0]     r_mem_wdata, w_mem_wdata_nxt;
  logic                r_mem_w_en, w_mem_w_en_nxt;
  logic                r_mem_rd_en, w_mem_rd_en_nxt;
  logic [XLEN-1:0]     w_ld_data;
  logic [XLEN-1:0]     w_st_word;

  lsu_align u_align (
    .i_funct3    (r_funct3),
    .i_addr_lo   (r_addr[1:0]),
    .i_rdata     (mem_rdata),
    .i_wdata     (r_wdata),
    .o_ld_data_c (w_ld_data),
    .o_st_word_c (w_st_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_funct3     <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_w_en   <= 1'b0;
      r_mem_rd_en  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_funct3     <= w_funct3_nxt;
      r_wdata      <= w_wdata_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_mem_w_en   <= w_mem_w_en_nxt;
      r_mem_rd_en  <= w_mem_rd_en_nxt;
    end
  end

  // Memory-side controls are registered for the state being entered, so they are zero in IDLE.
  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_funct3_nxt     = r_funct3;
    w_wdata_nxt      = r_wdata;
    w_resp_valid_nxt = 1'b0;
    w_resp_err_nxt   = 1'b0;
    w_resp_rdata_nxt = r_resp_rdata;
    w_mem_addr_nxt   = '0;
    w_mem_wdata_nxt  = '0;
    w_mem_w_en_nxt   = 1'b0;
    w_mem_rd_en_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_illegal(req_we, req_funct3, req_addr[1:0])) begin
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = 1'b1;
          end else begin
            w_addr_nxt     = req_addr;
            w_funct3_nxt   = req_funct3;
            w_wdata_nxt    = req_wdata[15:0];
            w_mem_addr_nxt = {req_addr[XLEN-1:2], 2'b00};
            if (!req_we) begin
              w_state_nxt     = ST_LOAD;
              w_mem_rd_en_nxt = 1'b1;
            end else if (req_funct3 == F3_W) begin
              w_state_nxt     = ST_WRITE;
              w_mem_w_en_nxt  = 1'b1;
              w_mem_wdata_nxt = req_wdata;
            end else begin
              w_state_nxt     = ST_RMW_RD;
              w_mem_rd_en_nxt = 1'b1;
            end
          end
        end
      end
      ST_LOAD: begin
        w_resp_rdata_nxt = w_ld_data;
        w_resp_valid_nxt = 1'b1;
        w_state_nxt      = ST_IDLE;
      end
      ST_RMW_RD: begin
        w_mem_addr_nxt  = {r_addr[XLEN-1:2], 2'b00};
        w_mem_wdata_nxt = w_st_word;
        w_mem_w_en_nxt  = 1'b1;
        w_state_nxt     = ST_WRITE;
      end
      ST_WRITE: begin
        w_resp_valid_nxt = 1'b1;
        w_state_nxt      = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign resp_valid  = r_resp_valid;
  assign resp_err    = r_resp_err;
  assign resp_rdata  = r_resp_rdata;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_w_en    = r_mem_w_en;
  assign mem_read_en = r_mem_rd_en;

endmodule
